// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: time bundle, lap FSM states, radix constants.
// Imported by lap_recorder and time_split_sub.
package stopwatch_pkg;

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] minute;
        logic [5:0] second;
        logic [6:0] m_sec;
    } time_t;

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        HOLD   = 2'd1,
        BROWSE = 2'd2
    } lap_state_t;

    localparam logic [6:0] MSEC_MOD = 7'd100;
    localparam logic [5:0] SEC_MOD  = 6'd60;
    localparam logic [5:0] MIN_MOD  = 6'd60;
    localparam logic [5:0] HOUR_MOD = 6'd24;

endpackage

// File: rtl/time_split_sub.sv
// Mixed-radix time subtractor: d = a - b, wrapping hours mod 24.
// Each field borrows from the next coarser one.
import stopwatch_pkg::*;

module time_split_sub (
    input  time_t a,
    input  time_t b,
    output time_t d
);

    logic b_ms;
    logic b_s;
    logic b_m;

    // Ripple the borrow from hundredths up to hours
    always_comb begin
        d    = '0;
        b_ms = a.m_sec < b.m_sec;
        d.m_sec = a.m_sec - b.m_sec
                + (b_ms ? MSEC_MOD : 7'd0);
        b_s  = {1'b0, a.second}
             < ({1'b0, b.second} + {6'd0, b_ms});
        d.second = a.second - b.second
                 - {5'd0, b_ms}
                 + (b_s ? SEC_MOD : 6'd0);
        b_m  = {1'b0, a.minute}
             < ({1'b0, b.minute} + {6'd0, b_s});
        d.minute = a.minute - b.minute
                 - {5'd0, b_s}
                 + (b_m ? MIN_MOD : 6'd0);
        d.hour = a.hour - b.hour
               - {5'd0, b_m}
               + ((a.hour < b.hour + {5'd0, b_m})
                  ? HOUR_MOD : 6'd0);
    end

endmodule

// File: rtl/lap_recorder.sv
// Lap capture / hold / browse selector for the stopwatch display.
// Define LAP_SPLIT_EN to show split times (not cumulative) while in HOLD.
import stopwatch_pkg::*;

module lap_recorder #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 150_000_000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     run,
    input  logic                     lap,
    input  logic                     recall,
    input  logic                     clear,
    input  logic [5:0]               hour,
    input  logic [5:0]               minute,
    input  logic [5:0]               second,
    input  logic [6:0]               m_sec,
    output logic [5:0]               disp_hour,
    output logic [5:0]               disp_minute,
    output logic [5:0]               disp_second,
    output logic [6:0]               disp_m_sec,
    output logic [$clog2(DEPTH)-1:0] lap_index,
    output logic                     showing_lap,
    output logic [$clog2(DEPTH):0]   lap_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(HOLD_CYCLES + 1);

    time_t            live_t;
    time_t            hold_view;
    time_t            disp_q;
    time_t            mem [DEPTH];
    lap_state_t       state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    oldest;
    logic [AW-1:0]    newest;
    logic [AW-1:0]    br_ptr;
    logic [TW-1:0]    timer;
    logic             do_clear;
    logic             do_lap;
    logic             do_recall;
    logic             browse_end;

    assign live_t = '{hour: hour, minute: minute,
                      second: second, m_sec: m_sec};

    // A lap with run low counts as absent, so a recall may still act
    assign do_clear  = clear;
    assign do_lap    = !clear && lap && run;
    assign do_recall = !clear && !do_lap && recall
                    && (lap_count != '0);

    assign oldest     = wr_ptr - lap_count[AW-1:0];
    assign newest     = wr_ptr - AW'(1);
    assign browse_end = (state == BROWSE) && (rd_ptr == newest);
    assign br_ptr     = (state == BROWSE) ? rd_ptr + AW'(1) : oldest;

`ifdef LAP_SPLIT_EN
    time_t prev_q;
    time_t split;

    time_split_sub u_split (
        .a (live_t),
        .b (prev_q),
        .d (split)
    );

    assign hold_view = split;

    // Previous capture; zero after clear so the first split is absolute
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      prev_q <= '0;
        else if (do_clear) prev_q <= '0;
        else if (do_lap)   prev_q <= live_t;
    end
`else
    assign hold_view = live_t;
`endif

    // Lap memory: contents need no reset, lap_count marks validity
    always_ff @(posedge clock) begin
        if (do_lap) mem[wr_ptr] <= live_t;
    end

    // Event handling, state machine and registered display outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LIVE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            lap_count   <= '0;
            timer       <= '0;
            disp_q      <= '0;
            lap_index   <= '0;
            showing_lap <= 1'b0;
        end else begin
            unique case (1'b1)
                do_clear: begin
                    state       <= LIVE;
                    wr_ptr      <= '0;
                    lap_count   <= '0;
                    timer       <= '0;
                    disp_q      <= live_t;
                    lap_index   <= '0;
                    showing_lap <= 1'b0;
                end
                do_lap: begin
                    state       <= HOLD;
                    wr_ptr      <= wr_ptr + AW'(1);
                    if (lap_count != (AW+1)'(DEPTH))
                        lap_count <= lap_count + (AW+1)'(1);
                    timer       <= TW'(HOLD_CYCLES - 1);
                    disp_q      <= hold_view;
                    lap_index   <= wr_ptr;
                    showing_lap <= 1'b1;
                end
                do_recall: begin
                    if (browse_end) begin
                        state       <= LIVE;
                        disp_q      <= live_t;
                        lap_index   <= '0;
                        showing_lap <= 1'b0;
                    end else begin
                        state       <= BROWSE;
                        rd_ptr      <= br_ptr;
                        disp_q      <= mem[br_ptr];
                        lap_index   <= br_ptr;
                        showing_lap <= 1'b1;
                    end
                end
                default: begin
                    unique case (state)
                        LIVE: disp_q <= live_t;
                        HOLD: begin
                            if (timer == '0) begin
                                state       <= LIVE;
                                disp_q      <= live_t;
                                lap_index   <= '0;
                                showing_lap <= 1'b0;
                            end else begin
                                timer <= timer - TW'(1);
                            end
                        end
                        BROWSE: ;
                        default: state <= LIVE;
                    endcase
                end
            endcase
        end
    end

    assign disp_hour   = disp_q.hour;
    assign disp_minute = disp_q.minute;
    assign disp_second = disp_q.second;
    assign disp_m_sec  = disp_q.m_sec;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed bench for lap_recorder (DEPTH=8, HOLD_CYCLES=20).
// Split-time checks apply when LAP_SPLIT_EN is defined.
module tb_lap_recorder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       run = 1'b0;
    logic       lap = 1'b0;
    logic       recall = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] hour = '0;
    logic [5:0] minute = '0;
    logic [5:0] second = '0;
    logic [6:0] m_sec = '0;
    logic [5:0] disp_hour;
    logic [5:0] disp_minute;
    logic [5:0] disp_second;
    logic [6:0] disp_m_sec;
    logic [2:0] lap_index;
    logic       showing_lap;
    logic [3:0] lap_count;

    int n_cmp = 0;
    int n_err = 0;

    lap_recorder #(.DEPTH(8), .HOLD_CYCLES(20)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .lap         (lap),
        .recall      (recall),
        .clear       (clear),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .m_sec       (m_sec),
        .disp_hour   (disp_hour),
        .disp_minute (disp_minute),
        .disp_second (disp_second),
        .disp_m_sec  (disp_m_sec),
        .lap_index   (lap_index),
        .showing_lap (showing_lap),
        .lap_count   (lap_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] tv(int h, int m, int s, int ms);
        return {7'b0, 6'(h), 6'(m), 6'(s), 7'(ms)};
    endfunction

    function automatic logic [31:0] dv();
        return {7'b0, disp_hour, disp_minute, disp_second, disp_m_sec};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_live(input int h, input int m,
                            input int s, input int ms);
        hour   = 6'(h);
        minute = 6'(m);
        second = 6'(s);
        m_sec  = 7'(ms);
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        step();
        lap = 1'b0;
    endtask

    task automatic pulse_recall();
        recall = 1'b1;
        step();
        recall = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_disp", dv(), tv(0, 0, 0, 0));
        chk("rst_show", 32'(showing_lap), 32'd0);
        chk("rst_cnt", 32'(lap_count), 32'd0);
        chk("rst_idx", 32'(lap_index), 32'd0);
        step();
        step();
        reset_n = 1'b1;

        set_live(0, 1, 2, 34);
        step();
        chk("live_disp", dv(), tv(0, 1, 2, 34));
        chk("live_show", 32'(showing_lap), 32'd0);
        chk("live_cnt", 32'(lap_count), 32'd0);

        run = 1'b1;
        set_live(0, 0, 5, 10);
        pulse_lap();
        set_live(0, 0, 7, 0);
        chk("hold_disp", dv(), tv(0, 0, 5, 10));
        chk("hold_cnt", 32'(lap_count), 32'd1);
        chk("hold_show", 32'(showing_lap), 32'd1);
        chk("hold_idx", 32'(lap_index), 32'd0);
        for (int i = 0; i < 19; i++) step();
        chk("hold_last_disp", dv(), tv(0, 0, 5, 10));
        chk("hold_last_show", 32'(showing_lap), 32'd1);
        step();
        chk("hold_end_show", 32'(showing_lap), 32'd0);
        chk("hold_end_disp", dv(), tv(0, 0, 7, 0));

        pulse_clear();
        chk("clr_cnt", 32'(lap_count), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            set_live(0, 0, i, i);
            pulse_lap();
        end
        chk("ring_cnt", 32'(lap_count), 32'd8);
        chk("ring_idx", 32'(lap_index), 32'd1);
        chk("ring_disp", dv(), tv(0, 0, 10, 10));

        set_live(1, 2, 3, 4);
        pulse_recall();
        chk("br_first_disp", dv(), tv(0, 0, 3, 3));
        chk("br_first_idx", 32'(lap_index), 32'd2);
        chk("br_first_show", 32'(showing_lap), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            pulse_recall();
            chk("br_step_disp", dv(), tv(0, 0, 3 + k, 3 + k));
            chk("br_step_idx", 32'(lap_index), 32'((2 + k) % 8));
        end
        for (int i = 0; i < 30; i++) step();
        chk("br_notimeout", 32'(showing_lap), 32'd1);
        chk("br_hold_disp", dv(), tv(0, 0, 10, 10));
        pulse_recall();
        chk("br_exit_show", 32'(showing_lap), 32'd0);
        chk("br_exit_disp", dv(), tv(1, 2, 3, 4));
        chk("br_exit_idx", 32'(lap_index), 32'd0);

        lap = 1'b1;
        clear = 1'b1;
        step();
        lap = 1'b0;
        clear = 1'b0;
        chk("lapclr_cnt", 32'(lap_count), 32'd0);
        chk("lapclr_show", 32'(showing_lap), 32'd0);
        run = 1'b0;
        set_live(0, 0, 9, 9);
        pulse_lap();
        chk("norun_cnt", 32'(lap_count), 32'd0);
        chk("norun_show", 32'(showing_lap), 32'd0);
        chk("norun_disp", dv(), tv(0, 0, 9, 9));
        pulse_recall();
        chk("rcl_empty_show", 32'(showing_lap), 32'd0);

        run = 1'b1;
        set_live(0, 0, 59, 90);
        pulse_lap();
        set_live(0, 1, 0, 5);
        pulse_lap();
`ifdef LAP_SPLIT_EN
        chk("split_sec", dv(), tv(0, 0, 0, 15));
`else
        chk("cum_sec", dv(), tv(0, 1, 0, 5));
`endif
        pulse_recall();
        chk("br_cum_disp", dv(), tv(0, 0, 59, 90));

        pulse_clear();
        set_live(23, 59, 59, 99);
        pulse_lap();
        chk("day_first", dv(), tv(23, 59, 59, 99));
        set_live(0, 0, 0, 1);
        pulse_lap();
`ifdef LAP_SPLIT_EN
        chk("split_day", dv(), tv(0, 0, 0, 2));
`else
        chk("cum_day", dv(), tv(0, 0, 0, 1));
`endif
        chk("day_cnt", 32'(lap_count), 32'd2);

        pulse_recall();
        chk("pre_rst_show", 32'(showing_lap), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_disp", dv(), tv(0, 0, 0, 0));
        chk("arst_show", 32'(showing_lap), 32'd0);
        chk("arst_cnt", 32'(lap_count), 32'd0);
        chk("arst_idx", 32'(lap_index), 32'd0);
        step();
        #2 reset_n = 1'b1;
        set_live(0, 3, 4, 5);
        pulse_recall();
        chk("post_rst_show", 32'(showing_lap), 32'd0);
        chk("post_rst_disp", dv(), tv(0, 3, 4, 5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
